// File: rtl/ysyx_23060077_riscv_ex_mdu.sv
// ysyx_23060077_riscv_ex_mdu
// Iterative RV32M multiply/divide unit for the EX stage. Requests arrive on a
// valid/ready channel, take 32 cycles (radix-2 shift-add multiply or restoring
// divide on operand magnitudes) and leave on a valid/ready response channel.
// Divide-by-zero and signed overflow bypass the datapath and answer at once.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a request, in_ready high (outside reset)
// S_BUSY | iterating, counter 0..31, one bit per cycle
// S_DONE | result held on mdu_out_data with out_valid until out_ready
module ysyx_23060077_riscv_ex_mdu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            mdu_opt,
    input  logic [DATA_WIDTH-1:0] mdu_a_data,
    input  logic [DATA_WIDTH-1:0] mdu_b_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] mdu_out_data
);

    localparam int W = DATA_WIDTH;
    localparam logic [5:0]   CNT_LAST = 6'(W - 1);
    localparam logic [W-1:0] INT_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q,  state_d;
    logic [5:0]     cnt_q,    cnt_d;
    logic [2:0]     opt_q,    opt_d;
    logic           neg_a_q,  neg_a_d;
    logic           neg_b_q,  neg_b_d;
    // multiplicand magnitude for multiplies, divisor magnitude for divides
    logic [W-1:0]   opnd_q,   opnd_d;
    // multiply: {partial product high, multiplier shifting out}; divide: low half
    // holds the dividend shifting out on the left and the quotient shifting in
    logic [2*W-1:0] acc_q,    acc_d;
    logic [W-1:0]   rem_q,    rem_d;
    logic [W-1:0]   result_q, result_d;

    logic           a_signed, b_signed;
    logic [W-1:0]   a_abs, b_abs;
    logic           is_div_in, div_by_zero, div_ovf, special;
    logic [W-1:0]   special_res;
    logic           accept;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;
    logic [W:0]     div_shift, div_diff;
    logic           div_ge;
    logic [W-1:0]   rem_step, quo_step;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, final_res;

    assign in_ready     = (state_q == S_IDLE) & ~rst;
    assign out_valid    = (state_q == S_DONE);
    assign mdu_out_data = result_q;

    // Request decode: operand signedness, magnitudes and divide special cases
    always_comb begin
        a_signed    = mdu_opt[2] ? ~mdu_opt[0] : (mdu_opt[1:0] != 2'b11);
        b_signed    = mdu_opt[2] ? ~mdu_opt[0] : ~mdu_opt[1];
        a_abs       = (a_signed && mdu_a_data[W-1]) ? -mdu_a_data : mdu_a_data;
        b_abs       = (b_signed && mdu_b_data[W-1]) ? -mdu_b_data : mdu_b_data;
        is_div_in   = mdu_opt[2];
        div_by_zero = is_div_in && (mdu_b_data == '0);
        div_ovf     = is_div_in && !mdu_opt[0] &&
                      (mdu_a_data == INT_MIN) && (mdu_b_data == ALL_ONES);
        special     = div_by_zero || div_ovf;
        // REM/REMU (funct3 bit 1 set) return the dividend / zero, DIV/DIVU all-ones / INT_MIN
        if (div_by_zero) begin
            special_res = mdu_opt[1] ? mdu_a_data : ALL_ONES;
        end else begin
            special_res = mdu_opt[1] ? '0 : INT_MIN;
        end
        accept = in_valid && in_ready && !flush;
    end

    // One datapath iteration plus the sign fixup applied on the last one
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[W-1:1]};

        div_shift = {rem_q, acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[W];
        rem_step  = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
        quo_step  = {acc_q[W-2:0], div_ge};

        prod_fix  = (neg_a_q ^ neg_b_q) ? -mul_step : mul_step;
        quo_fix   = (neg_a_q ^ neg_b_q) ? -quo_step : quo_step;
        rem_fix   = neg_a_q ? -rem_step : rem_step;

        if (opt_q[2]) begin
            final_res = opt_q[1] ? rem_fix : quo_fix;
        end else begin
            final_res = (opt_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        end
    end

    // Next-state logic for the controller and all datapath registers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opt_d    = opt_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opt_d   = mdu_opt;
                    neg_a_d = a_signed & mdu_a_data[W-1];
                    neg_b_d = b_signed & mdu_b_data[W-1];
                    cnt_d   = '0;
                    rem_d   = '0;
                    if (is_div_in) begin
                        opnd_d = b_abs;
                        acc_d  = {{W{1'b0}}, a_abs};
                    end else begin
                        opnd_d = a_abs;
                        acc_d  = {{W{1'b0}}, b_abs};
                    end
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 6'd1;
                if (opt_q[2]) begin
                    acc_d = {acc_q[2*W-1:W], quo_step};
                    rem_d = rem_step;
                end else begin
                    acc_d = mul_step;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abandon any in-flight work; the last delivered result stays visible
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opt_q    <= opt_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_riscv_ex_mdu.sv
// Testbench for ysyx_23060077_riscv_ex_mdu: directed RV32M cases, backpressure,
// flush/reset mid-operation and randomized operations against a plain
// 64-bit arithmetic reference of the RV32M rules.
module tb_ysyx_23060077_riscv_ex_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mdu_opt;
    logic [31:0] mdu_a_data;
    logic [31:0] mdu_b_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mdu_out_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_res;

    ysyx_23060077_riscv_ex_mdu #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mdu_opt      (mdu_opt),
        .mdu_a_data   (mdu_a_data),
        .mdu_b_data   (mdu_b_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mdu_out_data (mdu_out_data)
    );

    always #5 clk = ~clk;

    // RV32M result computed with 64-bit arithmetic
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sp;
        logic [63:0] ux, uy, p;
        sx = $signed({{32{x[31]}}, x});
        sy = $signed({{32{y[31]}}, y});
        ux = {32'h0, x};
        uy = {32'h0, y};
        p  = 64'h0;
        case (op)
            3'd0: begin sp = sx * sy; p = sp; return p[31:0]; end
            3'd1: begin sp = sx * sy; p = sp; return p[63:32]; end
            3'd2: begin sp = sx * $signed(uy); p = sp; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                sp = sx / sy; p = sp; return p[31:0];
            end
            3'd5: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 32'h0) return x;
                sp = sx % sy; p = sp; return p[31:0];
            end
            default: begin
                if (y == 32'h0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op[2] && (y == 32'h0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge, hold it through the accepting edge
    task automatic start_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input string tag);
        @(negedge clk);
        mdu_opt    = op;
        mdu_a_data = x;
        mdu_b_data = y;
        in_valid   = 1'b1;
        chk({tag, " in_ready"}, {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        mdu_a_data = $urandom;
        mdu_b_data = $urandom;
        mdu_opt    = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input string tag);
        int lat;
        logic [31:0] exp;
        exp = ref_mdu(op, x, y);
        start_op(op, x, y, tag);
        wait_valid(lat);
        chk({tag, " latency"}, 32'(lat), 32'(ref_lat(op, x, y)));
        chk({tag, " data"}, mdu_out_data, exp);
        last_res = exp;
        @(negedge clk);
        chk({tag, " out_valid after handshake"}, {31'h0, out_valid}, 32'h0);
        chk({tag, " in_ready after handshake"}, {31'h0, in_ready}, 32'h1);
    endtask

    task automatic no_valid_for(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk({tag, " no out_valid pulse"}, {31'h0, seen}, 32'h0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        logic [31:0] exp;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        mdu_opt    = 3'd0;
        mdu_a_data = 32'h0;
        mdu_b_data = 32'h0;
        last_res   = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset in_ready", {31'h0, in_ready}, 32'h0);
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset data", mdu_out_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", {31'h0, in_ready}, 32'h1);

        run_op(3'd0, 32'd7, 32'd6, "MUL 7*6");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH -1*-1");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU max*max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "MULHSU -1*2");
        run_op(3'd0, 32'h8000_0000, 32'd2, "MUL min*2");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "REM -7%2");
        run_op(3'd5, 32'd100, 32'd7, "DIVU 100/7");
        run_op(3'd7, 32'd100, 32'd7, "REMU 100%7");
        run_op(3'd5, 32'd5, 32'd0, "DIVU 5/0");
        run_op(3'd6, 32'd5, 32'd0, "REM 5%0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV min/-1");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM min%-1");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH min*min");
        run_op(3'd6, 32'd7, 32'hFFFF_FFFE, "REM 7%-2");

        // Backpressure: result must sit still while out_ready is low
        out_ready = 1'b0;
        exp = ref_mdu(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        start_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, "bp MULHU");
        wait_valid(lat);
        chk("bp latency", 32'(lat), 32'd33);
        chk("bp data", mdu_out_data, exp);
        repeat (10) begin
            @(negedge clk);
            chk("bp hold out_valid", {31'h0, out_valid}, 32'h1);
            chk("bp hold data", mdu_out_data, exp);
            chk("bp hold in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp single transfer", {31'h0, out_valid}, 32'h0);
        chk("bp in_ready back", {31'h0, in_ready}, 32'h1);
        last_res = exp;

        // A request presented together with flush is dropped
        @(negedge clk);
        mdu_opt = 3'd0; mdu_a_data = 32'd3; mdu_b_data = 32'd3;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush drop in_ready", {31'h0, in_ready}, 32'h1);
        chk("flush drop out_valid", {31'h0, out_valid}, 32'h0);

        // Flush at counter 10 of a multiply
        start_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, "flush MUL");
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush idle in_ready", {31'h0, in_ready}, 32'h1);
        chk("flush out_valid", {31'h0, out_valid}, 32'h0);
        chk("flush data unchanged", mdu_out_data, last_res);
        no_valid_for(40, "flush");
        run_op(3'd5, 32'd9, 32'd3, "DIVU 9/3 after flush");

        // Reset in the middle of a divide
        start_op(3'd4, 32'h7654_3210, 32'd13, "rst DIV");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst in_ready low", {31'h0, in_ready}, 32'h0);
        chk("rst out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst data cleared", mdu_out_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst release in_ready", {31'h0, in_ready}, 32'h1);
        no_valid_for(40, "rst");
        run_op(3'd5, 32'd9, 32'd3, "DIVU 9/3 after rst");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_riscv_ex_mdu.md
# ysyx_23060077_riscv_ex_mdu

Iterative multiply/divide unit for the RV32M instructions, the multi-cycle companion of the combinational EX-stage ALU. It accepts an operation and two operands over a valid/ready request channel and returns the 32-bit result over a valid/ready response channel. The EX stage stalls while the unit is busy, and the unit is flushed on pipeline redirect.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  abandon the in-flight operation; sync, takes priority over everything except rst.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- mdu_opt  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- mdu_a_data  input  DATA_WIDTH  rs1 operand (multiplicand/dividend).
- mdu_b_data  input  DATA_WIDTH  rs2 operand (multiplier/divisor).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- mdu_out_data  output  DATA_WIDTH  result.

## Operation
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) & ~rst; out_valid = (state==DONE).
- IDLE, in_valid & in_ready:
  - Latch opt, operand signs and magnitudes.
  - Signed operands (MUL/MULH/DIV/REM: both; MULHSU: a only) are converted to absolute value. Unsigned operands pass through.
  - Clear the 6-bit counter. Go to BUSY, unless a special case applies.
- Special cases, divide ops only, go IDLE->DONE directly:
  - Divisor==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give dividend unchanged.
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- BUSY multiply:
  - Radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - 32 cycles, counter 0..31.
- BUSY divide:
  - Restoring shift-subtract over a 33-bit partial remainder, one quotient bit per cycle, MSB first.
  - 32 cycles.
- BUSY with counter==31: apply sign fixup and register the result, go to DONE.
  - Product: negate the 64-bit magnitude if the signed-operand signs differ.
  - Quotient: negated if dividend sign != divisor sign (signed ops).
  - Remainder: takes the dividend sign (signed ops).
- Result select: MUL gives product[31:0]; MULH/MULHSU/MULHU give product[63:32]; DIV/DIVU give quotient; REM/REMU give remainder.
- DONE: hold mdu_out_data stable; on out_ready go to IDLE.
- No new request is accepted in the same cycle as the response handshake; in_ready rises the cycle after.
- flush in any state: next state IDLE, counter cleared, out_valid low next cycle, mdu_out_data unchanged. A request presented with flush asserted is dropped.
- Handshake rules: the upstream must hold in_valid and operands stable until accepted. Operand inputs are ignored outside the accept cycle.

## Timing
- Reset: state IDLE, out_valid=0, mdu_out_data=0, counter=0, all internal registers 0; in_ready=0 while rst high, 1 the cycle after.
- Normal op accepted at edge E: BUSY for edges E+1..E+32, out_valid=1 from the cycle after edge E+32 (33 cycles after acceptance). Held until out_ready.
- Special-case divide accepted at edge E: out_valid=1 the cycle after E.
- Throughput: at most one op per 34 cycles (normal) or per 2 cycles (special), with out_ready tied high.
- rst or flush mid-BUSY: IDLE on the next edge; no partial result is ever made visible.
- Results bit-exact to the RISC-V spec. All arithmetic is modulo 2^32 (2^64 for the product).

## Test plan
- Reset, then MUL a=7, b=6, out_ready=1: in_ready high; out_valid rises exactly 33 cycles after acceptance with 42; in_ready returns the cycle after the handshake.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0; MULHU same operands -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF; MUL a=0x80000000, b=2 -> 0.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF, and REM a=5, b=0 -> 5, each valid 1 cycle after acceptance; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM of the same -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE: out_valid and mdu_out_data stay stable and in_ready stays 0; raise out_ready and check a single transfer.
- Flush at BUSY counter=10, and separately assert rst mid-BUSY: IDLE next cycle, no out_valid pulse; a following DIVU 9/3 returns 3 with normal latency.
